// File: rtl/port_read_unit_if.sv
// Signal bundle between the node execution path / neighbour writers and the port read unit.
interface port_read_unit_if;
   logic       rd_req;
   logic [2:0] rd_src;
   logic       hlt;
   logic [3:0] wreq;
   logic [7:0] wdata0;
   logic [7:0] wdata1;
   logic [7:0] wdata2;
   logic [7:0] wdata3;
   logic [3:0] ackw;
   logic [7:0] rdata;
   logic       rdone;
   logic       busy;
   logic [1:0] last_src;
   logic       last_valid;
   logic [7:0] stall_cnt;

   modport slave (
      input  rd_req, rd_src, hlt, wreq, wdata0, wdata1, wdata2, wdata3,
      output ackw, rdata, rdone, busy, last_src, last_valid, stall_cnt
   );

   modport master (
      output rd_req, rd_src, hlt, wreq, wdata0, wdata1, wdata2, wdata3,
      input  ackw, rdata, rdone, busy, last_src, last_valid, stall_cnt
   );
endinterface

// File: rtl/port_read_unit.sv
// Blocking read from one of four neighbour ports, ANY (round-robin), LAST (port of the
// previous ANY grant) or NIL, with a saturating stall counter and abort via hlt.
module port_read_unit (
   input  logic            clk,
   input  logic            reset,
   port_read_unit_if.slave bus
);
   // state | meaning
   // IDLE  | no read pending, rd_req sampled
   // WAIT  | read pending, looking for a candidate port
   // ACK   | one-cycle ackw/rdone strobe, then back to IDLE
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;

   localparam logic [2:0] SRC_ANY  = 3'd4;
   localparam logic [2:0] SRC_LAST = 3'd5;

   logic [1:0] state_q, state_d;
   logic [2:0] src_q, src_d;
   logic [7:0] rdata_q, rdata_d;
   logic [3:0] ackw_q, ackw_d;
   logic [1:0] last_src_q, last_src_d;
   logic       last_valid_q, last_valid_d;
   logic [1:0] rr_ptr_q, rr_ptr_d;
   logic [7:0] stall_q, stall_d;

   logic       cand_ok;
   logic [1:0] cand_idx;
   logic       nil_rd;
   logic [1:0] scan_idx;
   logic [7:0] cand_data;

   // Descending scan so the port closest to rr_ptr is the last (winning) assignment.
   always_comb begin
      cand_ok  = 1'b0;
      cand_idx = 2'd0;
      nil_rd   = 1'b0;
      scan_idx = 2'd0;
      case (src_q)
         SRC_ANY: begin
            for (int i = 3; i >= 0; i--) begin
               scan_idx = rr_ptr_q + 2'(i);
               if (bus.wreq[scan_idx]) begin
                  cand_ok  = 1'b1;
                  cand_idx = scan_idx;
               end
            end
         end
         SRC_LAST: begin
            if (last_valid_q) begin
               cand_idx = last_src_q;
               cand_ok  = bus.wreq[last_src_q];
            end else begin
               nil_rd = 1'b1;
            end
         end
         3'd6, 3'd7: nil_rd = 1'b1;
         default: begin
            cand_idx = src_q[1:0];
            cand_ok  = bus.wreq[src_q[1:0]];
         end
      endcase
   end

   always_comb begin
      case (cand_idx)
         2'd0:    cand_data = bus.wdata0;
         2'd1:    cand_data = bus.wdata1;
         2'd2:    cand_data = bus.wdata2;
         default: cand_data = bus.wdata3;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      rdata_d      = rdata_q;
      ackw_d       = 4'b0000;
      last_src_d   = last_src_q;
      last_valid_d = last_valid_q;
      rr_ptr_d     = rr_ptr_q;
      stall_d      = stall_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.rd_req) begin
               src_d   = bus.rd_src;
               stall_d = 8'd0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.hlt) begin
               state_d = ST_IDLE;
            end else if (nil_rd) begin
               rdata_d = 8'd0;
               state_d = ST_ACK;
            end else if (cand_ok) begin
               rdata_d = cand_data;
               ackw_d  = 4'b0001 << cand_idx;
               state_d = ST_ACK;
               if (src_q == SRC_ANY) begin
                  last_src_d   = cand_idx;
                  last_valid_d = 1'b1;
                  rr_ptr_d     = cand_idx + 2'd1;
               end
            end else if (stall_q != 8'hFF) begin
               stall_d = stall_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         src_q        <= 3'd0;
         rdata_q      <= 8'd0;
         ackw_q       <= 4'b0000;
         last_src_q   <= 2'd0;
         last_valid_q <= 1'b0;
         rr_ptr_q     <= 2'd0;
         stall_q      <= 8'd0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         rdata_q      <= rdata_d;
         ackw_q       <= ackw_d;
         last_src_q   <= last_src_d;
         last_valid_q <= last_valid_d;
         rr_ptr_q     <= rr_ptr_d;
         stall_q      <= stall_d;
      end
   end

   assign bus.ackw       = ackw_q;
   assign bus.rdata      = rdata_q;
   assign bus.rdone      = (state_q == ST_ACK);
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.last_src   = last_src_q;
   assign bus.last_valid = last_valid_q;
   assign bus.stall_cnt  = stall_q;
endmodule

// File: tb/tb_port_read_unit.sv
// Directed bench for port_read_unit: a transaction-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_port_read_unit;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] wd [4];
   int         checks = 0;
   int         errors = 0;

   port_read_unit_if bif ();

   assign bif.wdata0 = wd[0];
   assign bif.wdata1 = wd[1];
   assign bif.wdata2 = wd[2];
   assign bif.wdata3 = wd[3];

   port_read_unit dut (.clk(clk), .reset(rst_n), .bus(bif));

   always #5 clk = ~clk;

   // model: a pending read either waits for a port or shows its one-cycle completion
   bit         m_waiting, m_acking;
   int         m_src, m_rr, m_stall;
   logic [7:0] m_rdata;
   logic [3:0] m_ackw;
   logic [1:0] m_last_src;
   bit         m_last_valid;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_waiting = 0; m_acking = 0; m_src = 0; m_rr = 0; m_stall = 0;
      m_rdata = 8'd0; m_ackw = 4'd0; m_last_src = 2'd0; m_last_valid = 0;
   endtask

   // -2: completes with no data, -1: nothing to take yet, else the port served
   function automatic int pick(input int src, input logic [3:0] wq);
      if (src <= 3) return wq[src] ? src : -1;
      if (src == 4) begin
         for (int i = 0; i < 4; i++) begin
            int q = (m_rr + i) % 4;
            if (wq[q]) return q;
         end
         return -1;
      end
      if (src == 5 && m_last_valid) return wq[m_last_src] ? int'(m_last_src) : -1;
      return -2;
   endfunction

   task automatic model_step();
      int p;
      m_ackw = 4'd0;
      if (m_acking) begin
         m_acking = 0;
      end else if (m_waiting) begin
         if (bif.hlt) begin
            m_waiting = 0;
         end else begin
            p = pick(m_src, bif.wreq);
            if (p == -2) begin
               m_rdata = 8'd0; m_waiting = 0; m_acking = 1;
            end else if (p >= 0) begin
               m_rdata = wd[p]; m_ackw = 4'(1 << p); m_waiting = 0; m_acking = 1;
               if (m_src == 4) begin
                  m_last_src = 2'(p); m_last_valid = 1; m_rr = (p + 1) % 4;
               end
            end else if (m_stall < 255) begin
               m_stall++;
            end
         end
      end else if (bif.rd_req) begin
         m_waiting = 1; m_src = int'(bif.rd_src); m_stall = 0;
      end
   endtask

   always @(negedge rst_n) model_reset();

   always @(posedge clk) begin
      if (!rst_n) model_reset();
      else model_step();
      #1;
      chk("ackw",       32'(bif.ackw),       32'(m_ackw));
      chk("rdone",      32'(bif.rdone),      32'(m_acking));
      chk("busy",       32'(bif.busy),       32'(m_waiting || m_acking));
      chk("rdata",      32'(bif.rdata),      32'(m_rdata));
      chk("last_src",   32'(bif.last_src),   32'(m_last_src));
      chk("last_valid", 32'(bif.last_valid), 32'(m_last_valid));
      chk("stall_cnt",  32'(bif.stall_cnt),  32'(m_stall));
      chk("ackw_onehot", 32'($onehot0(bif.ackw)), 32'd1);
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ackw"},  32'(bif.ackw), 32'd0);
      chk({tag, "_rdone"}, 32'(bif.rdone), 32'd0);
      chk({tag, "_busy"},  32'(bif.busy), 32'd0);
      chk({tag, "_rdata"}, 32'(bif.rdata), 32'd0);
      chk({tag, "_last"},  32'({bif.last_valid, bif.last_src}), 32'd0);
      chk({tag, "_stall"}, 32'(bif.stall_cnt), 32'd0);
   endtask

   task automatic apply_reset();
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   // request at one negedge, completion visible two negedges later
   task automatic read_chk(input string name, input logic [2:0] src,
                           input logic [3:0] exp_ackw, input logic [7:0] exp_rdata);
      @(negedge clk); bif.rd_req = 1'b1; bif.rd_src = src;
      @(negedge clk); bif.rd_req = 1'b0;
      @(negedge clk);
      chk({name, "_ackw"},  32'(bif.ackw),  32'(exp_ackw));
      chk({name, "_rdone"}, 32'(bif.rdone), 32'd1);
      chk({name, "_rdata"}, 32'(bif.rdata), 32'(exp_rdata));
      @(negedge clk);
      chk({name, "_done_low"}, 32'({bif.rdone, bif.ackw}), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      bif.rd_req = 1'b0; bif.rd_src = 3'd0; bif.hlt = 1'b0; bif.wreq = 4'd0;
      for (int i = 0; i < 4; i++) wd[i] = 8'd0;
      model_reset();
      #2 chk_all_zero("reset");
      @(negedge clk); rst_n = 1'b1;

      // direct read from port 2
      bif.wreq = 4'b0100; wd[2] = 8'h5A;
      read_chk("direct", 3'd2, 4'b0100, 8'h5A);
      chk("direct_stall", 32'(bif.stall_cnt), 32'd0);
      chk("direct_nolast", 32'(bif.last_valid), 32'd0);
      bif.wreq = 4'd0;

      // round-robin ANY from reset
      apply_reset();
      bif.wreq = 4'b1111; wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44;
      read_chk("any0", 3'd4, 4'b0001, 8'h11);
      read_chk("any1", 3'd4, 4'b0010, 8'h22);
      read_chk("any2", 3'd4, 4'b0100, 8'h33);
      read_chk("any3", 3'd4, 4'b1000, 8'h44);
      chk("any_last", 32'({bif.last_valid, bif.last_src}), 32'h7);
      bif.wreq = 4'd0;

      // LAST and NIL
      apply_reset();
      read_chk("last_cold", 3'd5, 4'b0000, 8'h00);
      bif.wreq = 4'b0010; wd[1] = 8'h77;
      read_chk("any_p1", 3'd4, 4'b0010, 8'h77);
      chk("any_p1_last", 32'({bif.last_valid, bif.last_src}), 32'h5);
      read_chk("last_p1", 3'd5, 4'b0010, 8'h77);
      read_chk("nil6", 3'd6, 4'b0000, 8'h00);
      bif.wreq = 4'd0;

      // stall saturation and abort
      @(negedge clk); bif.rd_req = 1'b1; bif.rd_src = 3'd0;
      @(negedge clk); bif.rd_req = 1'b0;
      repeat (300) @(negedge clk);
      chk("stall_sat", 32'(bif.stall_cnt), 32'd255);
      chk("stall_busy", 32'(bif.busy), 32'd1);
      bif.hlt = 1'b1;
      @(negedge clk); bif.hlt = 1'b0;
      chk("abort_busy", 32'(bif.busy), 32'd0);
      chk("abort_rdone", 32'(bif.rdone), 32'd0);
      @(negedge clk);
      chk("abort_quiet", 32'({bif.rdone, bif.ackw, bif.busy}), 32'd0);

      // hlt and wreq[3] rise together while waiting on port 3
      @(negedge clk); bif.rd_req = 1'b1; bif.rd_src = 3'd3;
      @(negedge clk); bif.rd_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("race_stall", 32'(bif.stall_cnt), 32'd3);
      wd[3] = 8'hE1; bif.wreq = 4'b1000; bif.hlt = 1'b1;
      @(negedge clk); bif.hlt = 1'b0;
      chk("race_ackw", 32'(bif.ackw), 32'd0);
      chk("race_state", 32'({bif.rdone, bif.busy}), 32'd0);
      @(negedge clk);
      chk("race_ackw2", 32'(bif.ackw), 32'd0);
      bif.wreq = 4'd0;

      // reset pulse in the middle of a read
      bif.wreq = 4'b0001; wd[0] = 8'hAB;
      read_chk("pre_rst", 3'd4, 4'b0001, 8'hAB);
      bif.wreq = 4'd0;
      @(negedge clk); bif.rd_req = 1'b1; bif.rd_src = 3'd1;
      @(negedge clk); bif.rd_req = 1'b0;
      @(negedge clk);
      chk("mid_busy", 32'(bif.busy), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("mid_rst");
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk_all_zero("post_rst");
      bif.wreq = 4'b0100; wd[2] = 8'hC3;
      read_chk("after_rst", 3'd2, 4'b0100, 8'hC3);
      bif.wreq = 4'd0;

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
